// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_data_t   : record handed to decode {raw_instr, pc, is_bubble}
//   fetch_state_t  : fetch FSM states
//   PCINIT_DEFAULT : reset PC
//   BUBBLE         : empty fetch_data_t (raw_instr=0, pc=0, is_bubble=1)
package fetch_stage_pkg;

   localparam logic [63:0] PCINIT_DEFAULT = 64'h8000_0000;

   typedef struct packed {
      logic [31:0] raw_instr;
      logic [63:0] pc;
      logic        is_bubble;
   } fetch_data_t;

   typedef enum logic [1:0] {
      S_REQ,    // request outstanding at pc
      S_HOLD,   // word captured while decode stalls; bus idle
      S_DRAIN   // stale request outstanding; its response is dropped
   } fetch_state_t;

   localparam fetch_data_t BUBBLE = '{raw_instr: 32'h0, pc: 64'h0, is_bubble: 1'b1};

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage directly upstream of decode.
// Owns the PC, drives the instruction bus with a valid/data_ok handshake and
// registers each fetched word into dataF, inserting bubbles while waiting.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ireq_valid, ireq_addr           instruction request (addr == pc)
//   iresp_data_ok, iresp_data       instruction response
//   stall                           decode cannot accept; hold dataF
//   redirect_valid, redirect_pc     taken control transfer from decode
//   dataF                           registered fetch record for decode
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [63:0] PCINIT = PCINIT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output fetch_data_t dataF
);

   fetch_state_t state, state_n;
   logic [63:0]  pc, pc_n;
   logic [63:0]  pending, pending_n;
   logic [31:0]  buf_instr, buf_instr_n;
   logic [63:0]  buf_pc, buf_pc_n;
   fetch_data_t  data_n;
   logic [63:0]  drain_target;

   always_comb begin
      // NOTE: every signal gets a hold-value default first so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_n      = state;
      pc_n         = pc;
      pending_n    = pending;
      buf_instr_n  = buf_instr;
      buf_pc_n     = buf_pc;
      data_n       = dataF;
      drain_target = redirect_valid ? redirect_pc : pending;

      // The bus sees the request in S_REQ and S_DRAIN; in S_DRAIN pc still
      // holds the stale address so valid/addr stay stable until data_ok.
      ireq_valid = !reset && (state != S_HOLD);
      ireq_addr  = pc;

      unique case (state)
         S_REQ: begin
            if (redirect_valid) begin
               data_n = BUBBLE;
               if (iresp_data_ok) begin
                  pc_n = redirect_pc;         // returning word is dropped
               end else begin
                  pending_n = redirect_pc;    // wait out the stale response
                  state_n   = S_DRAIN;
               end
            end else if (iresp_data_ok) begin
               pc_n = pc + 64'd4;             // wraps modulo 2^64
               if (stall) begin
                  buf_instr_n = iresp_data;
                  buf_pc_n    = pc;
                  state_n     = S_HOLD;
               end else begin
                  data_n = '{raw_instr: iresp_data, pc: pc, is_bubble: 1'b0};
               end
            end else if (!stall) begin
               data_n = BUBBLE;
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               pc_n    = redirect_pc;
               data_n  = BUBBLE;
               state_n = S_REQ;
            end else if (!stall) begin
               data_n  = '{raw_instr: buf_instr, pc: buf_pc, is_bubble: 1'b0};
               state_n = S_REQ;
            end
         end

         S_DRAIN: begin
            // A redirect arriving here replaces the pending target (latest wins).
            if (iresp_data_ok) begin
               pc_n    = drain_target;
               state_n = S_REQ;
            end else begin
               pending_n = drain_target;
            end
            if (redirect_valid || !stall) data_n = BUBBLE;
         end

         default: state_n = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state     <= S_REQ;
         pc        <= PCINIT;
         pending   <= '0;
         // NOTE: the one-entry skid buffer is reset too, so a word captured
         // before reset can never resurface.
         buf_instr <= '0;
         buf_pc    <= '0;
         dataF     <= BUBBLE;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         pending   <= pending_n;
         buf_instr <= buf_instr_n;
         buf_pc    <= buf_pc_n;
         dataF     <= data_n;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   fetch_data_t dataF;

   int total = 0;
   int bad   = 0;

   localparam logic [63:0] PC0 = 64'h8000_0000;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dataF          (dataF)
   );

   always #5 clk = ~clk;

   function automatic fetch_data_t word(input logic [31:0] instr, input logic [63:0] pc);
      word = '{raw_instr: instr, pc: pc, is_bubble: 1'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; iresp_data_ok = 1'b0; iresp_data = '0;
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      tick();
      total++;
      if (ireq_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", ireq_valid); end
      total++;
      if (dataF !== BUBBLE) begin bad++; $display("FAIL rst_dataF got=%h want=%h", dataF, BUBBLE); end
      reset = 1'b0;
      #1;
      total++;
      if (ireq_valid !== 1'b1) begin bad++; $display("FAIL rst_valid_after got=%b want=1", ireq_valid); end
      total++;
      if (ireq_addr !== PC0) begin bad++; $display("FAIL rst_addr got=%h want=%h", ireq_addr, PC0); end
   endtask

   // Zero-wait bus: one word per cycle at PC0, PC0+4, PC0+8.
   task automatic test_zero_wait();
      logic [31:0] w [3] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
      for (int i = 0; i < 3; i++) begin
         total++;
         if (ireq_addr !== PC0 + 64'(4 * i)) begin
            bad++; $display("FAIL zw_addr[%0d] got=%h want=%h", i, ireq_addr, PC0 + 64'(4 * i));
         end
         iresp_data_ok = 1'b1; iresp_data = w[i];
         tick();
         total++;
         if (dataF !== word(w[i], PC0 + 64'(4 * i))) begin
            bad++; $display("FAIL zw_dataF[%0d] got=%h want=%h", i, dataF, word(w[i], PC0 + 64'(4 * i)));
         end
      end
      iresp_data_ok = 1'b0;
   endtask

   // Response arrives after 3 wait cycles at PC0+0xC.
   task automatic test_delayed();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (ireq_valid !== 1'b1 || ireq_addr !== PC0 + 64'hC) begin
            bad++; $display("FAIL dly_req[%0d] got=%b/%h want=1/%h", i, ireq_valid, ireq_addr, PC0 + 64'hC);
         end
         tick();
         total++;
         if (dataF !== BUBBLE) begin bad++; $display("FAIL dly_bubble[%0d] got=%h want=%h", i, dataF, BUBBLE); end
      end
      iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_0001;
      tick();
      iresp_data_ok = 1'b0;
      total++;
      if (dataF !== word(32'hDEAD_0001, PC0 + 64'hC)) begin
         bad++; $display("FAIL dly_word got=%h want=%h", dataF, word(32'hDEAD_0001, PC0 + 64'hC));
      end
   endtask

   // Word returns while decode stalls for 2 cycles.
   task automatic test_stall();
      fetch_data_t prev = word(32'hDEAD_0001, PC0 + 64'hC);
      iresp_data_ok = 1'b1; iresp_data = 32'hCAFE_0010; stall = 1'b1;
      tick();
      iresp_data_ok = 1'b0;
      total++;
      if (dataF !== prev) begin bad++; $display("FAIL stl_frozen1 got=%h want=%h", dataF, prev); end
      total++;
      if (ireq_valid !== 1'b0) begin bad++; $display("FAIL stl_hold_valid got=%b want=0", ireq_valid); end
      tick();
      total++;
      if (dataF !== prev) begin bad++; $display("FAIL stl_frozen2 got=%h want=%h", dataF, prev); end
      stall = 1'b0;
      tick();
      total++;
      if (dataF !== word(32'hCAFE_0010, PC0 + 64'h10)) begin
         bad++; $display("FAIL stl_release got=%h want=%h", dataF, word(32'hCAFE_0010, PC0 + 64'h10));
      end
      total++;
      if (ireq_valid !== 1'b1 || ireq_addr !== PC0 + 64'h14) begin
         bad++; $display("FAIL stl_next_req got=%b/%h want=1/%h", ireq_valid, ireq_addr, PC0 + 64'h14);
      end
      // Stall with no response in S_REQ also freezes dataF.
      stall = 1'b1;
      tick();
      stall = 1'b0;
      total++;
      if (dataF !== word(32'hCAFE_0010, PC0 + 64'h10)) begin
         bad++; $display("FAIL stl_req_frozen got=%h want=%h", dataF, word(32'hCAFE_0010, PC0 + 64'h10));
      end
   endtask

   // Redirect while the request at PC0+0x14 is still outstanding.
   task automatic test_redirect_pending();
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
      tick();
      redirect_valid = 1'b0;
      total++;
      if (dataF !== BUBBLE) begin bad++; $display("FAIL rdp_bubble got=%h want=%h", dataF, BUBBLE); end
      tick();
      total++;
      if (ireq_valid !== 1'b1 || ireq_addr !== PC0 + 64'h14) begin
         bad++; $display("FAIL rdp_drain_req got=%b/%h want=1/%h", ireq_valid, ireq_addr, PC0 + 64'h14);
      end
      iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_BAD0;
      tick();
      iresp_data_ok = 1'b0;
      total++;
      if (dataF !== BUBBLE) begin bad++; $display("FAIL rdp_stale_dropped got=%h want=%h", dataF, BUBBLE); end
      total++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100) begin
         bad++; $display("FAIL rdp_target got=%b/%h want=1/%h", ireq_valid, ireq_addr, 64'h8000_0100);
      end
      iresp_data_ok = 1'b1; iresp_data = 32'h0100_0001;
      tick();
      iresp_data_ok = 1'b0;
      total++;
      if (dataF !== word(32'h0100_0001, 64'h8000_0100)) begin
         bad++; $display("FAIL rdp_first_word got=%h want=%h", dataF, word(32'h0100_0001, 64'h8000_0100));
      end
   endtask

   // Redirect in the same cycle the response for PC 0x8000_0104 arrives.
   task automatic test_redirect_data_ok();
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
      iresp_data_ok = 1'b1; iresp_data = 32'hBAD1_BAD1;
      tick();
      redirect_valid = 1'b0;
      total++;
      if (dataF !== BUBBLE) begin bad++; $display("FAIL rdo_bubble got=%h want=%h", dataF, BUBBLE); end
      total++;
      if (ireq_addr !== 64'h8000_0200) begin
         bad++; $display("FAIL rdo_target got=%h want=%h", ireq_addr, 64'h8000_0200);
      end
      iresp_data = 32'h0200_0001;
      tick();
      iresp_data_ok = 1'b0;
      total++;
      if (dataF !== word(32'h0200_0001, 64'h8000_0200)) begin
         bad++; $display("FAIL rdo_word got=%h want=%h", dataF, word(32'h0200_0001, 64'h8000_0200));
      end
   endtask

   // Redirect while a word sits in the skid buffer.
   task automatic test_hold_redirect();
      iresp_data_ok = 1'b1; iresp_data = 32'h0204_0001; stall = 1'b1;
      tick();
      iresp_data_ok = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
      tick();
      redirect_valid = 1'b0; stall = 1'b0;
      total++;
      if (dataF !== BUBBLE) begin bad++; $display("FAIL hrd_bubble got=%h want=%h", dataF, BUBBLE); end
      total++;
      if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0300) begin
         bad++; $display("FAIL hrd_target got=%b/%h want=1/%h", ireq_valid, ireq_addr, 64'h8000_0300);
      end
   endtask

   // PC increment wraps at the top of the address space.
   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      iresp_data_ok = 1'b1; iresp_data = 32'h0;
      tick();
      redirect_valid = 1'b0;
      iresp_data = 32'h7777_0001;
      tick();
      iresp_data_ok = 1'b0;
      total++;
      if (dataF !== word(32'h7777_0001, 64'hFFFF_FFFF_FFFF_FFFC)) begin
         bad++; $display("FAIL wrap_word got=%h want=%h", dataF, word(32'h7777_0001, 64'hFFFF_FFFF_FFFF_FFFC));
      end
      total++;
      if (ireq_addr !== 64'h0) begin bad++; $display("FAIL wrap_addr got=%h want=0", ireq_addr); end
   endtask

   // Reset asserted while in S_HOLD.
   task automatic test_reset_mid_hold();
      iresp_data_ok = 1'b1; iresp_data = 32'h5555_0001; stall = 1'b1;
      tick();
      iresp_data_ok = 1'b0;
      total++;
      if (ireq_valid !== 1'b0) begin bad++; $display("FAIL rmh_in_hold got=%b want=0", ireq_valid); end
      reset = 1'b1;
      tick();
      total++;
      if (dataF !== BUBBLE) begin bad++; $display("FAIL rmh_bubble got=%h want=%h", dataF, BUBBLE); end
      reset = 1'b0; stall = 1'b0;
      #1;
      total++;
      if (ireq_valid !== 1'b1 || ireq_addr !== PC0) begin
         bad++; $display("FAIL rmh_pcinit got=%b/%h want=1/%h", ireq_valid, ireq_addr, PC0);
      end
      tick();
      total++;
      if (dataF !== BUBBLE) begin bad++; $display("FAIL rmh_buf_cleared got=%h want=%h", dataF, BUBBLE); end
      iresp_data_ok = 1'b1; iresp_data = 32'h6666_0001;
      tick();
      iresp_data_ok = 1'b0;
      total++;
      if (dataF !== word(32'h6666_0001, PC0)) begin
         bad++; $display("FAIL rmh_first_word got=%h want=%h", dataF, word(32'h6666_0001, PC0));
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_delayed();
      test_stall();
      test_redirect_pending();
      test_redirect_data_ok();
      test_hold_redirect();
      test_wrap();
      test_reset_mid_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
